// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the hazard control unit and its record pipeline.
package hazard_control_unit_pkg;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } hazard_rec_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hcu_state_t;

   localparam logic [4:0] REG_X0    = 5'd0;
   localparam logic [4:0] HALT_REG  = 5'd17;
   localparam logic [4:0] HALT_CODE = 5'd10;

   function automatic logic rec_writes(input hazard_rec_t rec, input logic [4:0] r);
      return rec.valid & rec.reg_write & (rec.rd == r) & (r != REG_X0);
   endfunction

endpackage

// File: rtl/hazard_rec_pipe.sv
// Shadow of the in-flight register writers: ID/EX, EX/MEM and MEM/WB records.
module hazard_rec_pipe
   import hazard_control_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_i,
   input  logic        freeze_i,
   input  logic        bubble_i,
   input  hazard_rec_t id_rec_i,
   output hazard_rec_t ex_rec_o,
   output hazard_rec_t mem_rec_o,
   output hazard_rec_t wb_rec_o
);

   hazard_rec_t ex_q, mem_q, wb_q;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!freeze_i) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= bubble_i ? '0 : id_rec_i;
      end
   end

   assign ex_rec_o  = ex_q;
   assign mem_rec_o = mem_q;
   assign wb_rec_o  = wb_q;

endmodule

// File: rtl/hazard_control_unit.sv
// ID-side hazard control: load-use / ecall-x17 stalls, branch flush and the ecall halt drain.
// state  | meaning
// RUN    | normal issue, hazards resolved by stall/flush
// DRAIN  | halt accepted, bubbles fed while the pipeline empties
// HALTED | terminal until reset, records frozen
module hazard_control_unit #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter logic [4:0]  HALT_REG     = hazard_control_unit_pkg::HALT_REG
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_is_ecall,
   input  logic        id_halt_req,
   input  logic        ex_branch_taken,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        is_halted,
   output logic [31:0] stall_cycles
);
   import hazard_control_unit_pkg::*;

   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

   hcu_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       stall_q, stall_d;
   logic              freeze;
   logic              load_use, ecall_dep;
   hazard_rec_t       id_rec, ex_rec, mem_rec, wb_rec;

   assign id_rec = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

   hazard_rec_pipe u_rec_pipe (
      .clk       (clk),
      .rst_i     (reset),
      .freeze_i  (freeze),
      .bubble_i  (id_ex_bubble),
      .id_rec_i  (id_rec),
      .ex_rec_o  (ex_rec),
      .mem_rec_o (mem_rec),
      .wb_rec_o  (wb_rec)
   );

   // wb_r is covered by the WB-to-ID bypass, so it never stalls ID.
   logic unused_recs;
   assign unused_recs = &{1'b0, wb_rec, mem_rec.mem_read};

   assign load_use  = ex_rec.mem_read &
                      ((id_use_rs1 & rec_writes(ex_rec, id_rs1)) |
                       (id_use_rs2 & rec_writes(ex_rec, id_rs2)));
   assign ecall_dep = id_is_ecall &
                      (rec_writes(ex_rec, HALT_REG) | rec_writes(mem_rec, HALT_REG));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stall_d      = stall_q;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
      is_halted    = 1'b0;
      freeze       = 1'b0;
      unique case (state_q)
         RUN: begin
            if (ex_branch_taken) begin
               if_id_flush = 1'b1;
               pc_write    = 1'b1;
               if_id_write = 1'b1;
            end else if (load_use | ecall_dep) begin
               if (stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
            end else if (id_halt_req) begin
               state_d = DRAIN;
               cnt_d   = CNT_W'(DRAIN_CYCLES);
            end else begin
               pc_write     = 1'b1;
               if_id_write  = 1'b1;
               id_ex_bubble = 1'b0;
            end
         end
         DRAIN: begin
            if (cnt_q == CNT_W'(1)) state_d = HALTED;
            else                    cnt_d   = cnt_q - CNT_W'(1);
         end
         HALTED: begin
            is_halted = 1'b1;
            freeze    = 1'b1;
         end
         default: state_d = RUN;
      endcase
      // Outputs must be safe while reset is still asserted, independent of the clock.
      if (reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_bubble = 1'b1;
         is_halted    = 1'b0;
      end
   end

   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized and directed bench for hazard_control_unit against an in-flight-instruction model.
module tb_hazard_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
   logic        id_is_ecall, id_halt_req, ex_branch_taken;
   logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted;
   logic [31:0] stall_cycles;

   hazard_control_unit dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .id_rd           (id_rd),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .id_is_ecall     (id_is_ecall),
      .id_halt_req     (id_halt_req),
      .ex_branch_taken (ex_branch_taken),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .id_ex_bubble    (id_ex_bubble),
      .is_halted       (is_halted),
      .stall_cycles    (stall_cycles)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: the three most recently issued instructions, youngest first, plus the halt phase.
   typedef struct {
      bit         v;
      logic [4:0] rd;
      bit         rw;
      bit         mr;
   } flight_t;

   flight_t     flight[3];
   int          mode;          // 0 running, 1 draining, 2 halted
   int          drain_left;
   logic [31:0] m_stall;
   bit e_pc, e_ifid, e_flush, e_bub, e_halt, e_stall, e_accept;

   function automatic bit wr(input flight_t f, input logic [4:0] r);
      return f.v && f.rw && (f.rd == r) && (r != 5'd0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) flight[i] = '{v: 0, rd: 5'd0, rw: 0, mr: 0};
      mode = 0; drain_left = 0; m_stall = 32'd0;
   endtask

   task automatic model_eval();
      bit lu, ed;
      lu = flight[0].mr && ((id_use_rs1 && wr(flight[0], id_rs1)) ||
                            (id_use_rs2 && wr(flight[0], id_rs2)));
      ed = id_is_ecall && (wr(flight[0], 5'd17) || wr(flight[1], 5'd17));
      e_pc = 0; e_ifid = 0; e_flush = 0; e_bub = 1; e_halt = 0; e_stall = 0; e_accept = 0;
      if (mode == 0) begin
         if (ex_branch_taken)    begin e_flush = 1; e_pc = 1; e_ifid = 1; end
         else if (lu || ed)      e_stall = 1;
         else if (id_halt_req)   e_accept = 1;
         else                    begin e_pc = 1; e_ifid = 1; e_bub = 0; end
      end else if (mode == 2) begin
         e_halt = 1;
      end
   endtask

   task automatic model_advance();
      if (mode != 2) begin
         flight[2] = flight[1];
         flight[1] = flight[0];
         if (e_bub) flight[0] = '{v: 0, rd: 5'd0, rw: 0, mr: 0};
         else       flight[0] = '{v: 1, rd: id_rd, rw: id_reg_write, mr: id_mem_read};
      end
      if (e_stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (mode == 0 && e_accept) begin
         mode = 1; drain_left = 3;
      end else if (mode == 1) begin
         drain_left--;
         if (drain_left == 0) mode = 2;
      end
   endtask

   // Called shortly after a negedge with inputs already driven; ends at the next negedge.
   task automatic step();
      #1;
      model_eval();
      chk("pc_write",     {31'd0, pc_write},     {31'd0, e_pc});
      chk("if_id_write",  {31'd0, if_id_write},  {31'd0, e_ifid});
      chk("if_id_flush",  {31'd0, if_id_flush},  {31'd0, e_flush});
      chk("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, e_bub});
      chk("is_halted",    {31'd0, is_halted},    {31'd0, e_halt});
      chk("stall_cycles", stall_cycles, m_stall);
      model_advance();
      @(negedge clk);
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                        input logic [4:0] rd, input bit rw, input bit mr,
                        input bit ecall, input bit hreq, input bit br);
      id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      id_rd = rd; id_reg_write = rw; id_mem_read = mr;
      id_is_ecall = ecall; id_halt_req = hreq; ex_branch_taken = br;
   endtask

   task automatic nop();
      drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_pc_write",    {31'd0, pc_write},     32'd0);
      chk("rst_if_id_write", {31'd0, if_id_write},  32'd0);
      chk("rst_bubble",      {31'd0, id_ex_bubble}, 32'd1);
      chk("rst_flush",       {31'd0, if_id_flush},  32'd0);
      chk("rst_halted",      {31'd0, is_halted},    32'd0);
      chk("rst_stall",       stall_cycles,          32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [4:0] rand_reg();
      return ($urandom_range(0, 5) == 0) ? 5'd17 : 5'($urandom_range(0, 7));
   endfunction

   initial begin
      int halt_at;
      int halted_for;
      reset = 1'b1;
      nop();
      model_reset();
      @(negedge clk);
      do_reset();

      // Load-use: lw x5 ; add x6,x5,x7
      drive(5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0, 0); step();
      drive(5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 0, 0); step();
      step();
      chk("lu_count", stall_cycles, 32'd1);

      // Branch outranks a load-use hazard in the same cycle
      drive(5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0, 0); step();
      drive(5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0, 0, 1); step();
      nop(); step();
      chk("br_count", stall_cycles, 32'd1);

      // x0 load and ALU writer never stall
      drive(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0, 0); step();
      drive(5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 0, 0, 0); step();
      drive(5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, 0); step();
      drive(5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 0, 0, 0); step();
      chk("nostall_count", stall_cycles, 32'd1);

      // addi x17,x0,10 ; ecall -> 2 stalls then accept, halted 4 cycles later
      drive(5'd0, 5'd0, 1, 0, 5'd17, 1, 0, 0, 0, 0); step();
      drive(5'd17, 5'd0, 1, 0, 5'd0, 0, 0, 1, 1, 0); step(); step();
      chk("ecall_count", stall_cycles, 32'd3);
      chk("ecall_not_yet", {31'd0, pc_write | ~id_ex_bubble}, 32'd0);
      step();
      nop();
      halt_at = 0;
      for (int k = 1; k <= 10; k++) begin
         #1;
         if (is_halted && halt_at == 0) halt_at = k;
         step();
      end
      chk("halt_latency", halt_at, 32'd4);
      do_reset();

      // Reset two cycles into DRAIN
      drive(5'd17, 5'd0, 1, 0, 5'd0, 0, 0, 1, 1, 0); step();
      nop(); step(); step();
      do_reset();
      nop(); step();
      chk("post_rst_stall", stall_cycles, 32'd0);

      // Saturation of the stall counter
      force dut.stall_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_q;
      m_stall = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         drive(5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0, 0); step();
         drive(5'd0, 5'd5, 0, 1, 5'd6, 1, 0, 0, 0, 0); step();
         step();
      end
      chk("sat_value", stall_cycles, 32'hFFFF_FFFF);
      do_reset();

      // Random traffic
      halted_for = 0;
      for (int n = 0; n < 3000; n++) begin
         bit ec;
         ec = ($urandom_range(0, 9) == 0);
         drive(rand_reg(), rand_reg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               rand_reg(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
               ec, ec && ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
         if (mode == 2) halted_for++;
         if (halted_for > 4 || $urandom_range(0, 299) == 0) begin
            halted_for = 0;
            do_reset();
         end else begin
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
